td4_prog_mem: RTL

TD4_PROG_MEM -- requirements
Module: td4_prog_mem

---
 rtl/td4_prog_mem.sv | 101 ++++++++++
 1 files changed

// File: rtl/td4_prog_mem.sv
// TD4 program memory: a 16x8 instruction store read combinationally by the core,
// reloadable over a valid/ready byte stream while the core is held in reset.
//
// state  | meaning
// RUN    | core running, data = mem[addres], loader idle
// LOAD   | core held, accepting bytes into mem[wptr]
// SETTLE | image complete, core held for HOLD_CYCLES before release
module td4_prog_mem #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addres,
  output logic [7:0] data,
  input  logic       prog_start,
  input  logic [7:0] prog_byte,
  input  logic       prog_valid,
  output logic       prog_ready,
  output logic       prog_done,
  output logic       cpu_run
);

  typedef enum logic [1:0] {RUN, LOAD, SETTLE} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] wptr_q, wptr_d;
  logic [3:0] hold_q, hold_d;
  logic       done_q, done_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];
  logic       we;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      RUN: begin
        if (prog_start) begin
          state_d = LOAD;
          wptr_d  = 4'd0;
        end
      end
      LOAD: begin
        // a restart wins over a byte offered in the same cycle
        if (prog_start) begin
          wptr_d = 4'd0;
        end else if (prog_valid) begin
          we = 1'b1;
          if (wptr_q == 4'd15) begin
            state_d = SETTLE;
            hold_d  = HOLD_INIT;
          end else begin
            wptr_d = wptr_q + 4'd1;
          end
        end
      end
      SETTLE: begin
        hold_d = hold_q - 4'd1;
        if (hold_q <= 4'd1) begin
          hold_d  = 4'd0;
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wptr_q] = prog_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wptr_q  <= 4'd0;
      hold_q  <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
    end
  end

  // data is forced to zero whenever writes are possible, so reads never see a write in flight
  assign cpu_run    = (state_q == RUN);
  assign prog_ready = (state_q == LOAD);
  assign prog_done  = done_q;
  assign data       = cpu_run ? mem_q[addres] : 8'h00;

endmodule
